// File: rtl/counter_run_ctrl.sv
// Purpose : run controller for an external up counter; sequences clear/run/pause/done
//           from single-cycle command pulses, paces increments with a prescaler and
//           detects a programmable terminal count (one-shot or auto-reload).
// Latency : cnt_en/cnt_clr are combinational from state and commands; done is
//           registered, one cycle after the terminal is seen.
// Backpressure: none. Commands are one-cycle pulses; a pulse that is not legal in
//           the current state is dropped.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   start/stop/clear  command pulses (start/resume/restart, pause, abort)
//   mode_reload       0 = one-shot, 1 = auto-reload; sampled with term_val
//   term_val          terminal count, latched on an accepted start
//   count_in          current counter value
//   cnt_en, cnt_clr   counter increment enable / synchronous clear
//   done              one-cycle pulse when the terminal was reached
//   busy              high in CLR, RUN, PAUSE
//   state             IDLE=0, CLR=1, RUN=2, PAUSE=3, DONE=4
module counter_run_ctrl #(
  parameter int WIDTH = 12,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode_reload,
  input  logic [WIDTH-1:0] term_val,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             done,
  output logic             busy,
  output logic [2:0]       state
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] term_q,  term_d;
  logic             mode_q,  mode_d;
  logic             done_q,  done_d;

  logic             term_hit;
  logic             presc_last;

  always_comb begin
    term_hit   = (state_q == S_RUN) && (count_in >= term_q);
    presc_last = (presc_q == PRESC_MAX);

    state_d = state_q;
    term_d  = term_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    // Priority: clear > term_hit > stop > start.
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CLR;
            term_d  = term_val;
            mode_d  = mode_reload;
          end
        end
        S_CLR: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          if (term_hit) begin
            state_d = mode_q ? S_CLR : S_DONE;
            done_d  = 1'b1;
          end else if (stop) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (start) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_CLR;
            term_d  = term_val;
            mode_d  = mode_reload;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // The prescaler only advances while RUN continues into RUN. On the pause
    // edge it keeps its value so that a resume picks up the same phase and the
    // suppressed increment of the stop cycle is not lost.
    if ((state_q == S_RUN) && (state_d == S_RUN)) begin
      presc_d = presc_last ? '0 : presc_q + PW'(1);
    end else if ((state_d == S_RUN) || (state_d == S_PAUSE)) begin
      presc_d = presc_q;
    end else begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      term_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Increment is suppressed on the terminal cycle and whenever a command that
  // leaves RUN is present, so the counter never overshoots term_q.
  assign cnt_en  = (state_q == S_RUN) && presc_last && !term_hit && !clear && !stop;
  assign cnt_clr = (state_q == S_CLR) || clear || !reset;
  assign busy    = (state_q == S_CLR) || (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done    = done_q;
  assign state   = state_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: two instances (DIV=4 and DIV=1), each driving a
// small behavioural up counter. A cycle-level model is compared every cycle and
// directed scenarios are pinned with hand-computed cycle numbers.
module tb_counter_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, stop, clear, mode;
  logic [11:0] term, cnt;
  logic        en, clr, done, busy;
  logic [2:0]  st;

  logic        start1, stop1, clear1, mode1;
  logic [11:0] term1, cnt1;
  logic        en1, clr1, done1, busy1;
  logic [2:0]  st1;

  counter_run_ctrl #(.WIDTH(12), .DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .mode_reload(mode), .term_val(term), .count_in(cnt),
    .cnt_en(en), .cnt_clr(clr), .done(done), .busy(busy), .state(st));

  counter_run_ctrl #(.WIDTH(12), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop1), .clear(clear1),
    .mode_reload(mode1), .term_val(term1), .count_in(cnt1),
    .cnt_en(en1), .cnt_clr(clr1), .done(done1), .busy(busy1), .state(st1));

  // External counters: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 12'd1;
    if (clr1) cnt1 <= '0;
    else if (en1) cnt1 <= cnt1 + 12'd1;
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int t0 = 0;
  int t1 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act === ex) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, ex);
  endtask

  task automatic chk_q(input string nm, input int got[$], input int want[$]);
    bit ok;
    ok = (got.size() == want.size());
    if (ok) foreach (got[i]) if (got[i] != want[i]) ok = 1'b0;
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d entries (first %0d), expected %0d entries (first %0d)",
                  nm, got.size(), (got.size() > 0) ? got[0] : -1,
                  want.size(), (want.size() > 0) ? want[0] : -1);
  endtask

  // ---- Reference model: phase number, RUN-cycle tick count, latched term/mode.
  typedef struct {
    int ph;    // 0 idle, 1 clearing, 2 running, 3 paused, 4 finished
    int tick;  // RUN cycles elapsed in this run segment (held while paused)
    bit rel;
    int term;
    bit dn;
  } mdl_t;

  typedef struct {
    bit en;
    bit clr;
    bit dn;
    bit busy;
    int st;
  } exp_t;

  function automatic exp_t m_out(mdl_t m, int div, bit rst, bit sp, bit cl, int c);
    exp_t e;
    bit hit;
    hit    = (m.ph == 2) && (c >= m.term);
    e.en   = (m.ph == 2) && ((m.tick % div) == div - 1) && !hit && !cl && !sp;
    e.clr  = (m.ph == 1) || cl || !rst;
    e.dn   = m.dn;
    e.busy = (m.ph >= 1) && (m.ph <= 3);
    e.st   = m.ph;
    return e;
  endfunction

  function automatic mdl_t m_next(mdl_t m, bit rst, bit sa, bit sp, bit cl, bit md, int tv, int c);
    mdl_t n;
    bit hit;
    n   = m;
    hit = (m.ph == 2) && (c >= m.term);
    if (!rst) begin
      n.ph = 0; n.tick = 0; n.rel = 0; n.term = 0; n.dn = 0;
      return n;
    end
    n.dn = hit && !cl;
    if (cl) begin
      n.ph = 0; n.tick = 0;
    end else begin
      case (m.ph)
        0, 4: if (sa) begin n.ph = 1; n.term = tv; n.rel = md; n.tick = 0; end
        1: begin n.ph = 2; n.tick = 0; end
        2: begin
          if (hit) begin n.ph = m.rel ? 1 : 4; n.tick = 0; end
          else if (sp) n.ph = 3;
          else n.tick = m.tick + 1;
        end
        3: if (sa) n.ph = 2;
        default: n.ph = 0;
      endcase
    end
    return n;
  endfunction

  mdl_t m0 = '{ph: 0, tick: 0, rel: 0, term: 0, dn: 0};
  mdl_t m1 = '{ph: 0, tick: 0, rel: 0, term: 0, dn: 0};

  int en_log[$], done_log[$], clr_log[$];
  int st15 = -1;
  int n_en1 = 0, first_en1 = -1, last_en1 = -1, n_done1 = 0, done_rel1 = -1;
  bit wrap1 = 1'b0;

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    exp_t e, e1;
    e  = m_out(m0, 4, reset, stop, clear, int'(cnt));
    e1 = m_out(m1, 1, reset, stop1, clear1, int'(cnt1));
    chk("cnt_en", 32'(en), 32'(e.en));
    chk("cnt_clr", 32'(clr), 32'(e.clr));
    chk("done", 32'(done), 32'(e.dn));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("state", 32'(st), e.st);
    chk("div1_cnt_en", 32'(en1), 32'(e1.en));
    chk("div1_cnt_clr", 32'(clr1), 32'(e1.clr));
    chk("div1_done", 32'(done1), 32'(e1.dn));
    chk("div1_busy", 32'(busy1), 32'(e1.busy));
    chk("div1_state", 32'(st1), e1.st);

    if (en) en_log.push_back(cyc - t0);
    if (done) done_log.push_back(cyc - t0);
    if (clr) clr_log.push_back(cyc - t0);
    if (cyc - t0 == 15) st15 = int'(st);

    if ((st1 == 3'd2) && (cnt1 == 12'd0) && (n_en1 > 0)) wrap1 = 1'b1;
    if (en1) begin
      n_en1++;
      if (first_en1 < 0) first_en1 = cyc - t1;
      last_en1 = cyc - t1;
    end
    if (done1) begin n_done1++; done_rel1 = cyc - t1; end

    m0 = m_next(m0, reset, start, stop, clear, mode, int'(term), int'(cnt));
    m1 = m_next(m1, reset, start1, stop1, clear1, mode1, int'(term1), int'(cnt1));
  end

  // ---- Stimulus helpers
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_logs();
    en_log.delete(); done_log.delete(); clr_log.delete(); st15 = -1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0; tick();
  endtask

  task automatic kick(input int tv, input bit md);
    clr_logs();
    term = 12'(tv); mode = md;
    t0 = cyc; start = 1'b1; tick(); start = 1'b0;
  endtask

  int ex[$];

  task automatic check_s1();
    ex = '{5, 9, 13};  chk_q("s1_en_cycles", en_log, ex);
    ex = '{15};        chk_q("s1_done_cycles", done_log, ex);
    ex = '{1};         chk_q("s1_clr_cycles", clr_log, ex);
    chk("s1_state_at_15", st15, 4);
    chk("s1_final_count", 32'(cnt), 3);
    chk("s1_final_state", 32'(st), 4);
  endtask

  initial begin
    reset = 1'b0; start = 0; stop = 0; clear = 0; mode = 0; term = '0;
    start1 = 0; stop1 = 0; clear1 = 0; mode1 = 0; term1 = '0;

    // Reset state
    tick(3);
    chk("rst_state", 32'(st), 0);
    chk("rst_cnt_clr", 32'(clr), 1);
    chk("rst_cnt_en", 32'(en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    tick(2);

    // 1: one-shot, term 3
    kick(3, 1'b0); tick(24);
    check_s1();
    do_clear();

    // 2: auto-reload, term 3, period 14
    kick(3, 1'b1); tick(44);
    ex = '{15, 29, 43};                   chk_q("s2_done_cycles", done_log, ex);
    ex = '{1, 15, 29, 43};                chk_q("s2_clr_cycles", clr_log, ex);
    ex = '{5, 9, 13, 19, 23, 27, 33, 37, 41}; chk_q("s2_en_cycles", en_log, ex);
    do_clear();

    // 3: pause at cycle 7, 20 cycles paused, resume; term change ignored
    kick(10, 1'b0);
    term = 12'd2;
    tick(6);
    stop = 1'b1; tick(); stop = 1'b0;
    tick(19);
    start = 1'b1; tick(); start = 1'b0;
    tick(45);
    ex = '{5};
    for (int k = 0; k < 9; k++) ex.push_back(30 + 4 * k);
    chk_q("s3_en_cycles", en_log, ex);
    ex = '{64}; chk_q("s3_done_cycles", done_log, ex);
    chk("s3_final_count", 32'(cnt), 10);
    do_clear();

    // 4: clear+stop together at count 5, then term 0
    kick(10, 1'b0); tick(21);
    chk("s4_count_before_clear", 32'(cnt), 5);
    clear = 1'b1; stop = 1'b1; #1;
    chk("s4_cnt_clr_on_clear", 32'(clr), 1);
    tick(); clear = 1'b0; stop = 1'b0;
    chk("s4_state_after_clear", 32'(st), 0);
    chk("s4_count_after_clear", 32'(cnt), 0);
    tick(10);
    ex = '{}; chk_q("s4_no_done", done_log, ex);
    kick(0, 1'b0); tick(5);
    ex = '{3}; chk_q("s4_term0_done", done_log, ex);
    ex = '{};  chk_q("s4_term0_no_en", en_log, ex);
    chk("s4_term0_count", 32'(cnt), 0);
    do_clear();

    // 5: reset mid-run at count 7, then scenario 1 again
    kick(10, 1'b0); tick(29);
    chk("s5_count_before_reset", 32'(cnt), 7);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("s5_state_after_reset", 32'(st), 0);
    chk("s5_done_after_reset", 32'(done), 0);
    chk("s5_count_after_reset", 32'(cnt), 0);
    tick(2);
    kick(3, 1'b0); tick(24);
    check_s1();

    // 6: DIV=1, full-range terminal
    term1 = 12'hFFF; mode1 = 1'b0;
    t1 = cyc; start1 = 1'b1; tick(); start1 = 1'b0;
    tick(4105);
    chk("s6_en_count", n_en1, 4095);
    chk("s6_first_en", first_en1, 2);
    chk("s6_last_en", last_en1, 4096);
    chk("s6_done_count", n_done1, 1);
    chk("s6_done_cycle", done_rel1, 4098);
    chk("s6_no_wrap", 32'(wrap1), 0);
    chk("s6_final_count", 32'(cnt1), 32'hFFF);
    chk("s6_final_state", 32'(st1), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
Run controller for the 12-bit up counter (external `UpCounter`-style datapath).
- Sequences the counter through clear / run / pause / done using single-cycle command pulses (already debounced).
- Paces increments with an internal prescaler.
- Detects a programmable terminal count, in one-shot or auto-reload mode.
- Sits between the board-level button/switch logic and the counter; drives the counter's enable and clear inputs and reads its count back.

Parameters:
- WIDTH, 12, counter/terminal width in bits
- DIV, 4, clocks per counter increment while running (legal range DIV >= 1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse: start / resume / restart
- stop  in  1  one-cycle pulse: pause
- clear  in  1  one-cycle pulse: abort and clear counter
- mode_reload  in  1  0 = one-shot, 1 = auto-reload at terminal; sampled with term_val
- term_val  in  WIDTH  terminal count, latched into term_q on accepted start
- count_in  in  WIDTH  current value from the counter
- cnt_en  out  1  counter increment enable
- cnt_clr  out  1  counter synchronous clear
- done  out  1  one-cycle pulse: terminal reached
- busy  out  1  high in CLR, RUN, PAUSE
- state  out  3  FSM state: IDLE=0, CLR=1, RUN=2, PAUSE=3, DONE=4

Behaviour:
- **Reset** (reset=0 at clock edge):
  - state=IDLE, presc=0, term_q=0, mode_q=0, done=0.
  - cnt_clr=1 combinationally while reset=0; cnt_en=0.
- **Counter contract:** counter increments on an edge where cnt_en=1 and clears on an edge where cnt_clr=1. Clear has priority. count_in reflects the update the next cycle.
- **Prescaler** presc (ceil(log2(DIV)) bits, min 1):
  - Counts 0..DIV-1 and wraps, only in RUN.
  - Holds in PAUSE.
  - Forced to 0 in IDLE, CLR and DONE.
- **Terminal:** term_hit = (state==RUN) && (count_in >= term_q).
- **Outputs (combinational):**
  - cnt_en = (state==RUN) && (presc==DIV-1) && !term_hit && !clear && !stop.
  - cnt_clr = (state==CLR) || clear || !reset.
- **done:** registered; high exactly one cycle after a term_hit transition.
- **Transitions** (priority within a cycle: clear > term_hit > stop > start):
  - Any state, clear=1 -> IDLE. Counter is cleared by the cnt_clr asserted that cycle.
  - IDLE: start -> CLR; latch term_q=term_val, mode_q=mode_reload.
  - CLR: always -> RUN after one cycle (presc=0).
  - RUN:
    - term_hit with mode_q=0 -> DONE, done pulse.
    - term_hit with mode_q=1 -> CLR, done pulse; term_q kept.
    - stop -> PAUSE.
    - start ignored.
  - PAUSE: start -> RUN, presc resumes from held value; stop ignored.
  - DONE: start -> CLR with re-latch of term_val/mode_reload; otherwise hold. cnt_en=0.
- **Boundary cases:**
  - term_val=0: term_hit on first RUN cycle, no increments.
  - DIV=1: cnt_en every RUN cycle.
  - Increment period in RUN is DIV clocks.
  - Auto-reload period = term_q*DIV + 2 clocks.
  - term_val changes outside an accepted start have no effect.
  - stop and start in the same cycle in RUN -> PAUSE.
  - reset mid-run -> IDLE next edge; counter cleared.

Test Plan:
1. Reset, then start at cycle 0 with DIV=4, term_val=3, mode_reload=0:
   - cnt_clr at cycle 1.
   - cnt_en at cycles 5, 9, 13.
   - count_in reaches 3 at cycle 14; state=DONE and done=1 at cycle 15 only.
   - cnt_en stays 0 afterwards.
2. Same as 1 with mode_reload=1:
   - done pulses at cycles 15, 29, 43.
   - cnt_clr at cycles 15, 29.
   - count sequence 0..3 repeats, period 14.
3. Run with term_val=10, stop at cycle 7 (presc=1), hold 20 cycles, then start:
   - No cnt_en during PAUSE.
   - First cnt_en after resume comes exactly 2 cycles after returning to RUN.
   - Final done still occurs after 10 increments.
4. During RUN, assert clear and stop in the same cycle at count=5:
   - cnt_clr=1 that cycle; state=IDLE next; count_in=0; no done.
   - term_val=0 start: done one cycle after entering RUN, zero increments.
5. Pull reset low for one edge while in RUN at count=7:
   - state=IDLE, done=0, count_in=0 next cycle.
   - start afterward behaves exactly as scenario 1.
6. DIV=1, term_val=12'hFFF, one-shot:
   - cnt_en on 4095 consecutive RUN cycles.
   - done exactly once; count_in never wraps to 0 before DONE.
